unidad_control: RTL and testbench

- Control unit for the single-cycle microcontroller datapath (microc).
- Consumes Opcode and the registered zero flag z from the datapath, and drives s_inc, s_inm, we3, wez and Op back into it.
- Adds sequencing: a boot wait cycle for the synchronous program memory, a HALT state, debug single-step with a step/ack handshake, and a retired-instruction counter.
- pc_we is the load enable of the datapath PC register.

---
 rtl/unidad_control.sv | 131 +++++++++++++
 tb/tb_unidad_control.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/unidad_control.sv
// Control unit for the single-cycle microc datapath: decode, boot/halt sequencing, debug stepping.
// Define RETIRE_CNT_EN to build the retired-instruction counter; otherwise instr_count reads 0.
module unidad_control #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   input  logic             dbg_mode,
   input  logic             dbg_step,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             pc_we,
   output logic             halted,
   output logic             step_ack,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   step_ack_q, step_ack_d;

   logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_pc_we;
   logic [2:0] dec_op;
   logic       is_halt_op;
   logic       exec;
   logic       in_run;
   logic       run_exec;

   assign exec       = ~dbg_mode | dbg_step;
   assign in_run     = (state_q == StRun);
   assign run_exec   = in_run & exec & ~reset;
   assign is_halt_op = (Opcode == 6'b111111);

   // Opcode decode, independent of state; gated below.
   always_comb begin
      dec_s_inc = 1'b1;
      dec_s_inm = 1'b0;
      dec_we3   = 1'b0;
      dec_wez   = 1'b0;
      dec_pc_we = 1'b1;
      dec_op    = 3'b000;
      unique casez (Opcode)
         6'b0?????: begin
            dec_op  = Opcode[4:2];
            dec_we3 = 1'b1;
            dec_wez = 1'b1;
         end
         6'b1000??: begin
            dec_s_inm = 1'b1;
            dec_we3   = 1'b1;
         end
         6'b100100: dec_s_inc = 1'b0;
         6'b101000: dec_s_inc = ~z;
         6'b101001: dec_s_inc = z;
         6'b111111: dec_pc_we = 1'b0;
         default:   ;
      endcase
   end

   always_comb begin
      s_inc = 1'b1;
      s_inm = 1'b0;
      Op    = 3'b000;
      we3   = 1'b0;
      wez   = 1'b0;
      pc_we = 1'b0;
      if (in_run) begin
         s_inc = dec_s_inc;
         s_inm = dec_s_inm;
         Op    = dec_op;
      end
      if (run_exec) begin
         we3   = dec_we3;
         wez   = dec_wez;
         pc_we = dec_pc_we;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_ack_d = in_run & dbg_mode & dbg_step;
      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   if (exec && is_halt_op) state_d = StHalt;
         StHalt:  state_d = StHalt;
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StBoot;
         step_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_ack_q <= step_ack_d;
      end
   end

   assign halted   = (state_q == StHalt);
   assign step_ack = step_ack_q;

`ifdef RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_d = (run_exec && !is_halt_op) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign instr_count = cnt_q;
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: directed steps followed by random stimulus vs a model.
module tb_unidad_control;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset, z, dbg_mode, dbg_step;
   logic [5:0]    Opcode;
   logic          s_inc, s_inm, we3, wez, pc_we, halted, step_ack;
   logic [2:0]    Op;
   logic [CW-1:0] instr_count;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: machine phase as flags, retired count as a plain integer.
   bit m_boot = 1'b1;
   bit m_halt = 1'b0;
   bit m_ack  = 1'b0;
   int m_cnt  = 0;

   unidad_control #(.CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .Opcode      (Opcode),
      .z           (z),
      .dbg_mode    (dbg_mode),
      .dbg_step    (dbg_step),
      .s_inc       (s_inc),
      .s_inm       (s_inm),
      .we3         (we3),
      .wez         (wez),
      .Op          (Op),
      .pc_we       (pc_we),
      .halted      (halted),
      .step_ack    (step_ack),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int model_count();
`ifdef RETIRE_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   // Drive one cycle of inputs, check outputs against the model, then advance the model.
   task automatic step(input bit rst, input logic [5:0] op, input bit zz, input bit dm, input bit ds);
      bit e_pc, e_we3, e_wez, e_inc, e_inm, chk_dp, ex;
      int e_op;
      @(negedge clk);
      reset = rst; Opcode = op; z = zz; dbg_mode = dm; dbg_step = ds;
      #1;
      ex = !dm || ds;
      e_pc = 0; e_we3 = 0; e_wez = 0; e_inc = 1; e_inm = 0; e_op = 0; chk_dp = 0;
      if (!rst && m_boot) begin
         chk_dp = 1;
      end else if (!rst && !m_halt && ex) begin
         chk_dp = (op != 63);
         if (op < 32) begin
            e_op = op / 4; e_we3 = 1; e_wez = 1; e_pc = 1;
         end else if (op < 36) begin
            e_inm = 1; e_we3 = 1; e_pc = 1;
         end else if (op == 36) begin
            e_inc = 0; e_pc = 1;
         end else if (op == 40) begin
            e_inc = !zz; e_pc = 1;
         end else if (op == 41) begin
            e_inc = zz; e_pc = 1;
         end else if (op != 63) begin
            e_pc = 1;
         end
      end
      check("pc_we", 16'(pc_we), 16'(e_pc));
      check("we3", 16'(we3), 16'(e_we3));
      check("wez", 16'(wez), 16'(e_wez));
      if (chk_dp) begin
         check("s_inc", 16'(s_inc), 16'(e_inc));
         check("s_inm", 16'(s_inm), 16'(e_inm));
         check("Op", 16'(Op), 16'(e_op));
      end
      check("halted", 16'(halted), 16'(m_halt));
      check("step_ack", 16'(step_ack), 16'(m_ack));
      check("instr_count", 16'(instr_count), 16'(model_count()));
      @(posedge clk);
      if (rst) begin
         m_boot = 1; m_halt = 0; m_ack = 0; m_cnt = 0;
      end else begin
         m_ack = !m_boot && !m_halt && dm && ds;
         if (m_boot) m_boot = 0;
         else if (!m_halt && ex) begin
            if (op == 63) m_halt = 1;
            else m_cnt = (m_cnt + 1) % (1 << CW);
         end
      end
   endtask

   initial begin
      reset = 1; Opcode = '0; z = 0; dbg_mode = 0; dbg_step = 0;
      // Reset, boot, first ALU instruction.
      step(1, 6'b000000, 0, 0, 0);
      step(1, 6'b000000, 0, 0, 0);
      step(0, 6'b001000, 0, 0, 0);
      step(0, 6'b001000, 0, 0, 0);
      // Conditional jumps, LI, NOP.
      step(0, 6'b101000, 1, 0, 0);
      step(0, 6'b101000, 0, 0, 0);
      step(0, 6'b101001, 1, 0, 0);
      step(0, 6'b101001, 0, 0, 0);
      step(0, 6'b100100, 0, 0, 0);
      step(0, 6'b100010, 0, 0, 0);
      step(0, 6'b110000, 0, 0, 0);
      // Debug stall then one step, then held step.
      for (int i = 0; i < 3; i++) step(0, 6'b000100, 0, 1, 0);
      step(0, 6'b000100, 0, 1, 1);
      step(0, 6'b000100, 0, 1, 0);
      step(0, 6'b000100, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 6'b011100, 0, 1, 1);
      step(0, 6'b011100, 0, 0, 0);
      // Stepped HALT still acks; halted state ignores opcodes.
      step(0, 6'b111111, 0, 1, 1);
      step(0, 6'b000000, 0, 0, 0);
      step(0, 6'b001000, 0, 0, 0);
      step(1, 6'b001000, 0, 0, 0);
      step(0, 6'b001000, 0, 0, 0);
      // Wrap of a 4-bit counter after 17 retired instructions.
      for (int i = 0; i < 17; i++) step(0, 6'b000000, 0, 0, 0);
      step(0, 6'b000000, 0, 0, 0);
      step(1, 6'b000000, 0, 0, 0);
      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         int sel;
         sel = $urandom_range(0, 9);
         case (sel)
            0: op = 6'b100100;
            1: op = 6'b101000;
            2: op = 6'b101001;
            3: op = ($urandom_range(0, 7) == 0) ? 6'b111111 : 6'b100001;
            default: op = 6'($urandom);
         endcase
         step(($urandom_range(0, 24) == 0), op, 1'($urandom), 1'($urandom),
              1'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
